// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the hazard/forwarding controller.
package hazard_ctrl_pkg;

  localparam int unsigned SH_REG_W  = 5;
  localparam int unsigned SH_TNEW_W = 2;

  // Forward-mux select encodings
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Tuse / Tnew values
  localparam logic [SH_TNEW_W-1:0] TUSE_NOW  = 2'd0;
  localparam logic [SH_TNEW_W-1:0] TUSE_E    = 2'd1;
  localparam logic [SH_TNEW_W-1:0] TUSE_M    = 2'd2;
  localparam logic [SH_TNEW_W-1:0] TUSE_NONE = 2'd3;
  localparam logic [SH_TNEW_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [SH_TNEW_W-1:0] TNEW_CAL  = 2'd1;
  localparam logic [SH_TNEW_W-1:0] TNEW_LOAD = 2'd2;

  // Producer view of a shadow entry
  typedef struct packed {
    logic                 valid;
    logic [SH_REG_W-1:0]  dst;
    logic [SH_TNEW_W-1:0] tnew;
  } prod_t;

  // Saturating countdown applied on every stage advance
  function automatic logic [SH_TNEW_W-1:0] tnew_step(input logic [SH_TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - SH_TNEW_W'(1);
  endfunction

  // A stage can forward to operand r only once its result is final
  function automatic logic fwd_hit(input prod_t p, input logic [SH_REG_W-1:0] r);
    return p.valid && (p.dst != '0) && (p.dst == r) && (p.tnew == '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_pick.sv
// Priority matcher: youngest ready producer (E > M > W) among enabled stages.
module hazard_fwd_pick
  import hazard_ctrl_pkg::*;
(
  input  logic [SH_REG_W-1:0] i_reg,
  input  logic [2:0]          i_srch,  // [2]=E, [1]=M, [0]=W
  input  prod_t               i_e,
  input  prod_t               i_m,
  input  prod_t               i_w,
  output logic [1:0]          o_sel
);

  // Pick the youngest enabled stage holding final data for i_reg
  always_comb begin
    o_sel = FWD_RF;
    if (i_srch[2] && fwd_hit(i_e, i_reg)) begin
      o_sel = FWD_E;
    end else if (i_srch[1] && fwd_hit(i_m, i_reg)) begin
      o_sel = FWD_M;
    end else if (i_srch[0] && fwd_hit(i_w, i_reg)) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the five-stage MIPS pipeline.
// Keeps a shadow of E/M/W destinations and Tnew counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W  = SH_REG_W,
  parameter int unsigned TNEW_W = SH_TNEW_W
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [REG_W-1:0] d_dst,
  input  logic             d_rwe,
  input  logic             d_cal_r,
  input  logic             d_cal_i,
  input  logic             d_load,
  input  logic             d_store,
  input  logic             d_branch,
  input  logic             d_jump_i,
  input  logic             d_jump_r,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic             fwd_m_rt
);

  // Only fields that some consumer reads are kept per stage
  prod_t             r_e_prod;
  prod_t             r_m_prod;
  prod_t             r_w_prod;
  logic [REG_W-1:0]  r_e_rs;
  logic [REG_W-1:0]  r_e_rt;
  logic [REG_W-1:0]  r_m_rt;

  logic [TNEW_W-1:0] w_tuse_rs;
  logic [TNEW_W-1:0] w_tuse_rt;
  logic [TNEW_W-1:0] w_d_tnew;
  logic [REG_W-1:0]  w_d_dst;
  logic              w_stall;
  prod_t             w_e_next;
  prod_t             w_m_next;
  prod_t             w_w_next;
  logic [1:0]        w_sel_m_rt;

  function automatic logic op_hazard(input logic [REG_W-1:0]  r,
                                     input logic [TNEW_W-1:0] tuse,
                                     input prod_t             e,
                                     input prod_t             m);
    return (r != '0) &&
           ((e.valid && (e.dst == r) && (e.tnew > tuse)) ||
            (m.valid && (m.dst == r) && (m.tnew > tuse)));
  endfunction

  // D-stage operand Tuse from instruction class
  always_comb begin
    w_tuse_rs = TUSE_NONE;
    w_tuse_rt = TUSE_NONE;
    if (d_branch || d_jump_r) begin
      w_tuse_rs = TUSE_NOW;
    end else if (d_cal_r || d_cal_i || d_load || d_store) begin
      w_tuse_rs = TUSE_E;
    end
    if (d_branch) begin
      w_tuse_rt = TUSE_NOW;
    end else if (d_cal_r) begin
      w_tuse_rt = TUSE_E;
    end else if (d_store) begin
      w_tuse_rt = TUSE_M;
    end
  end

  // D-stage Tnew at E entry and effective destination
  always_comb begin
    w_d_tnew = TNEW_NONE;
    if (d_cal_r || d_cal_i) begin
      w_d_tnew = TNEW_CAL;
    end else if (d_load) begin
      w_d_tnew = TNEW_LOAD;
    end else if (d_jump_i) begin
      w_d_tnew = TNEW_NONE;
    end
    w_d_dst = d_rwe ? d_dst : '0;
  end

  assign w_stall = op_hazard(d_rs, w_tuse_rs, r_e_prod, r_m_prod) ||
                   op_hazard(d_rt, w_tuse_rt, r_e_prod, r_m_prod);
  assign stall   = w_stall;

  // Next shadow entries; tnew also counts down into W so a retiring load reads as ready
  always_comb begin
    w_e_next = '0;
    if (!w_stall) begin
      w_e_next.valid = 1'b1;
      w_e_next.dst   = w_d_dst;
      w_e_next.tnew  = w_d_tnew;
    end
    w_m_next      = r_e_prod;
    w_m_next.tnew = tnew_step(r_e_prod.tnew);
    w_w_next      = r_m_prod;
    w_w_next.tnew = tnew_step(r_m_prod.tnew);
  end

  // Shadow pipeline shift; stall injects a bubble into E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_prod <= '0;
      r_m_prod <= '0;
      r_w_prod <= '0;
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_m_rt   <= '0;
    end else begin
      r_e_prod <= w_e_next;
      r_e_rs   <= w_stall ? '0 : d_rs;
      r_e_rt   <= w_stall ? '0 : d_rt;
      r_m_prod <= w_m_next;
      r_m_rt   <= r_e_rt;
      r_w_prod <= w_w_next;
    end
  end

  hazard_fwd_pick u_pick_d_rs (
    .i_reg(d_rs), .i_srch(3'b111),
    .i_e(r_e_prod), .i_m(r_m_prod), .i_w(r_w_prod), .o_sel(fwd_d_rs)
  );

  hazard_fwd_pick u_pick_d_rt (
    .i_reg(d_rt), .i_srch(3'b111),
    .i_e(r_e_prod), .i_m(r_m_prod), .i_w(r_w_prod), .o_sel(fwd_d_rt)
  );

  hazard_fwd_pick u_pick_e_rs (
    .i_reg(r_e_rs), .i_srch(3'b011),
    .i_e(r_e_prod), .i_m(r_m_prod), .i_w(r_w_prod), .o_sel(fwd_e_rs)
  );

  hazard_fwd_pick u_pick_e_rt (
    .i_reg(r_e_rt), .i_srch(3'b011),
    .i_e(r_e_prod), .i_m(r_m_prod), .i_w(r_w_prod), .o_sel(fwd_e_rt)
  );

  hazard_fwd_pick u_pick_m_rt (
    .i_reg(r_m_rt), .i_srch(3'b001),
    .i_e(r_e_prod), .i_m(r_m_prod), .i_w(r_w_prod), .o_sel(w_sel_m_rt)
  );

  assign fwd_m_rt = (w_sel_m_rt == FWD_W);

endmodule
